mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Instruction/data arbiter onto a single-outstanding memory    |
// |               port with starvation guard and response timeout.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

package mem_arbiter_pkg;
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic        d_wr_en,
    input  mem_size_t   d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,

    output logic        m_req,
    output logic        m_wr_en,
    output mem_size_t   m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,

    output logic        err
);

    localparam int SW = ($clog2(STARVE_MAX + 1) > 2) ? $clog2(STARVE_MAX + 1) : 2;
    localparam int WW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [SW-1:0] c_STARVE_MAX = SW'(STARVE_MAX);
    localparam logic [WW-1:0] c_TIMEOUT    = WW'(TIMEOUT);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_BUSY_I = 2'd1;
    localparam logic [1:0] c_BUSY_D = 2'd2;

    logic [1:0]    r_state;
    logic [SW-1:0] r_starve_cnt;
    logic [WW-1:0] r_wait_cnt;

    logic [1:0]    w_state_nxt;
    logic [SW-1:0] w_starve_nxt;
    logic [WW-1:0] w_wait_nxt;
    logic          w_grant_i;
    logic          w_grant_d;
    logic          w_done_i;
    logic          w_done_d;
    logic          w_timeout;
    logic          w_live;
    logic          w_issue_i;
    logic          w_issue_d;

    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve_cnt;
        w_wait_nxt   = r_wait_cnt;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done_i     = 1'b0;
        w_done_d     = 1'b0;
        w_timeout    = 1'b0;

        case (r_state)
            c_IDLE: begin
                // Data side wins contention until the instruction side has lost STARVE_MAX times.
                if (i_req && (!d_req || (r_starve_cnt == c_STARVE_MAX))) begin
                    w_grant_i = 1'b1;
                end else if (d_req) begin
                    w_grant_d = 1'b1;
                end

                if (w_grant_i) begin
                    w_state_nxt  = c_BUSY_I;
                    w_starve_nxt = '0;
                    w_wait_nxt   = '0;
                end else if (w_grant_d) begin
                    w_state_nxt = c_BUSY_D;
                    w_wait_nxt  = '0;
                    if (i_req && (r_starve_cnt != c_STARVE_MAX)) begin
                        w_starve_nxt = r_starve_cnt + 1'b1;
                    end
                end
            end

            c_BUSY_I, c_BUSY_D: begin
                if (r_wait_cnt == c_TIMEOUT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_IDLE;
                end else if (m_rvalid) begin
                    w_done_i    = (r_state == c_BUSY_I);
                    w_done_d    = (r_state == c_BUSY_D);
                    w_state_nxt = c_IDLE;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Outputs are combinational from state, so they are masked while reset is held.
    assign w_live    = reset_n;
    assign w_issue_i = w_live & w_grant_i;
    assign w_issue_d = w_live & w_grant_d;

    always_comb begin
        i_gnt    = w_issue_i;
        d_gnt    = w_issue_d;
        m_req    = w_issue_i | w_issue_d;
        m_wr_en  = w_issue_d & d_wr_en;
        m_size   = SIZE_BYTE;
        m_addr   = '0;
        m_wdata  = '0;
        i_rvalid = w_live & w_done_i;
        d_rvalid = w_live & w_done_d;
        i_rdata  = '0;
        d_rdata  = '0;
        err      = w_live & w_timeout;

        if (w_issue_i) begin
            m_size = SIZE_WORD;
            m_addr = i_addr;
        end else if (w_issue_d) begin
            m_size = d_size;
            m_addr = d_addr;
        end

        if (w_issue_i || w_issue_d) begin
            m_wdata = d_wdata;
        end

        if (i_rvalid) begin
            i_rdata = m_rdata;
        end
        if (d_rvalid) begin
            d_rdata = m_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_wait_cnt   <= w_wait_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Directed scoreboard bench for mem_arbiter.                   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    typedef struct packed {
        logic        iv;
        logic        dv;
        logic [31:0] ird;
        logic [31:0] drd;
    } resp_t;

    logic        clk;
    logic        reset_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_wr_en;
    mem_size_t   d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_wr_en;
    mem_size_t   m_size;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        err;

    int    errors = 0;
    int    checks = 0;
    logic  exp_err = 1'b0;
    resp_t sb[$];

    mem_arbiter #(
        .STARVE_MAX (3),
        .TIMEOUT    (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_wr_en  (d_wr_en),
        .d_size   (d_size),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_wr_en  (m_wr_en),
        .m_size   (m_size),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_rdata  (m_rdata),
        .m_rvalid (m_rvalid),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every sampled cycle pops one expected response (or expects none) and checks err.
    task automatic settle();
        resp_t e;
        @(negedge clk);
        if (sb.size() > 0) e = sb.pop_front();
        else               e = '0;
        chk("i_rvalid", 32'(i_rvalid), 32'(e.iv));
        chk("d_rvalid", 32'(d_rvalid), 32'(e.dv));
        chk("i_rdata",  i_rdata, e.ird);
        chk("d_rdata",  d_rdata, e.drd);
        chk("err",      32'(err), 32'(exp_err));
    endtask

    task automatic push_i(input logic [31:0] data);
        sb.push_back('{iv: 1'b1, dv: 1'b0, ird: data, drd: 32'h0});
    endtask

    task automatic push_d(input logic [31:0] data);
        sb.push_back('{iv: 1'b0, dv: 1'b1, ird: 32'h0, drd: data});
    endtask

    task automatic chk_grant(input string tag, input logic ig, input logic dg,
                             input logic [31:0] addr);
        chk({tag, "_i_gnt"}, 32'(i_gnt), 32'(ig));
        chk({tag, "_d_gnt"}, 32'(d_gnt), 32'(dg));
        chk({tag, "_m_req"}, 32'(m_req), 32'(ig | dg));
        if (ig | dg) chk({tag, "_m_addr"}, m_addr, addr);
    endtask

    initial begin
        logic exp_is_i [8];
        exp_is_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        reset_n  = 1'b0;
        i_req    = 1'b1;
        i_addr   = 32'h0;
        d_req    = 1'b0;
        d_wr_en  = 1'b0;
        d_size   = SIZE_BYTE;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        m_rdata  = 32'h0;
        m_rvalid = 1'b0;

        // Reset held with a pending request: nothing may be granted.
        settle();
        chk_grant("rst", 1'b0, 1'b0, 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);

        // Single instruction read, response two cycles after grant.
        step(); reset_n = 1'b1; i_addr = 32'h100;
        settle();
        chk_grant("rd", 1'b1, 1'b0, 32'h100);
        chk("rd_m_wr_en", 32'(m_wr_en), 32'h0);
        chk("rd_m_size", 32'(m_size), 32'(SIZE_WORD));
        step(); i_req = 1'b0;
        settle();
        chk_grant("rd_busy", 1'b0, 1'b0, 32'h0);
        step(); m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF; push_i(32'hDEADBEEF);
        settle();
        step(); m_rvalid = 1'b0;
        settle();

        // Contention with zero starvation: data first, instruction after d_req drops.
        step();
        i_req = 1'b1; i_addr = 32'h80;
        d_req = 1'b1; d_wr_en = 1'b1; d_size = SIZE_HALF; d_addr = 32'h40; d_wdata = 32'h1234;
        settle();
        chk_grant("cont_d", 1'b0, 1'b1, 32'h40);
        chk("cont_m_wr_en", 32'(m_wr_en), 32'h1);
        chk("cont_m_size", 32'(m_size), 32'(SIZE_HALF));
        step(); d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11; push_d(32'h11);
        settle();
        chk_grant("cont_busy", 1'b0, 1'b0, 32'h0);
        step(); m_rvalid = 1'b0;
        settle();
        chk_grant("cont_i", 1'b1, 1'b0, 32'h80);
        chk("cont_i_wr_en", 32'(m_wr_en), 32'h0);
        chk("cont_i_size", 32'(m_size), 32'(SIZE_WORD));
        chk("cont_i_wdata", m_wdata, 32'h1234);
        step(); i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h22; push_i(32'h22);
        settle();
        step(); m_rvalid = 1'b0; d_wr_en = 1'b0;
        settle();

        // Starvation: both held, single-cycle memory.
        for (int k = 0; k < 8; k++) begin
            step();
            i_req = 1'b1; d_req = 1'b1; m_rvalid = 1'b0;
            i_addr = 32'h300 + 32'(k); d_addr = 32'h200 + 32'(k); d_size = SIZE_WORD;
            settle();
            chk_grant($sformatf("starve%0d", k), exp_is_i[k], !exp_is_i[k],
                      exp_is_i[k] ? 32'h300 + 32'(k) : 32'h200 + 32'(k));
            step(); m_rvalid = 1'b1; m_rdata = 32'hA000 + 32'(k);
            if (exp_is_i[k]) push_i(32'hA000 + 32'(k));
            else             push_d(32'hA000 + 32'(k));
            settle();
            chk_grant($sformatf("starve%0d_busy", k), 1'b0, 1'b0, 32'h0);
        end
        step(); i_req = 1'b0; d_req = 1'b0; m_rvalid = 1'b0;
        settle();

        // Byte write.
        step(); d_req = 1'b1; d_wr_en = 1'b1; d_size = SIZE_BYTE; d_addr = 32'h23; d_wdata = 32'hAB;
        settle();
        chk_grant("wr", 1'b0, 1'b1, 32'h23);
        chk("wr_m_wr_en", 32'(m_wr_en), 32'h1);
        chk("wr_m_size", 32'(m_size), 32'(SIZE_BYTE));
        chk("wr_m_wdata", m_wdata, 32'hAB);
        step(); d_req = 1'b0; d_wr_en = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55555555;
        push_d(32'h55555555);
        settle();
        step(); m_rvalid = 1'b0;
        settle();

        // Stray response in IDLE is ignored, arbiter still idle afterwards.
        step(); m_rvalid = 1'b1; m_rdata = 32'h77;
        settle();
        chk_grant("stray", 1'b0, 1'b0, 32'h0);
        step(); m_rvalid = 1'b0; d_req = 1'b1; d_size = SIZE_HALF; d_addr = 32'h44;
        settle();
        chk_grant("after_stray", 1'b0, 1'b1, 32'h44);
        chk("after_stray_size", 32'(m_size), 32'(SIZE_HALF));
        step(); d_req = 1'b0;
        settle();
        step(); m_rvalid = 1'b1; m_rdata = 32'h4444; push_d(32'h4444);
        settle();
        step(); m_rvalid = 1'b0;
        settle();

        // Response on the last cycle before timeout still completes.
        step(); i_req = 1'b1; i_addr = 32'h400;
        settle();
        chk_grant("late_ok", 1'b1, 1'b0, 32'h400);
        step(); i_req = 1'b0;
        settle();
        for (int c = 1; c < 15; c++) begin
            step();
            settle();
        end
        step(); m_rvalid = 1'b1; m_rdata = 32'h1515; push_i(32'h1515);
        settle();
        step(); m_rvalid = 1'b0;
        settle();

        // Timeout: no response for 16 busy cycles.
        step(); i_req = 1'b1; i_addr = 32'h500;
        settle();
        chk_grant("to", 1'b1, 1'b0, 32'h500);
        for (int c = 0; c < 16; c++) begin
            step(); i_req = 1'b0;
            settle();
            chk("to_wait_m_req", 32'(m_req), 32'h0);
        end
        step(); exp_err = 1'b1;
        settle();
        exp_err = 1'b0;
        step(); m_rvalid = 1'b1; m_rdata = 32'hBAD;
        settle();
        step(); m_rvalid = 1'b0; d_req = 1'b1; d_addr = 32'h600; d_size = SIZE_WORD;
        settle();
        chk_grant("after_to", 1'b0, 1'b1, 32'h600);
        step(); d_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h600D; push_d(32'h600D);
        settle();
        step(); m_rvalid = 1'b0;
        settle();

        // Reset in BUSY_D, then stale response, then fresh instruction grant.
        step(); d_req = 1'b1; d_addr = 32'h60;
        settle();
        chk_grant("rbusy", 1'b0, 1'b1, 32'h60);
        step(); d_req = 1'b0; reset_n = 1'b0; i_req = 1'b1; i_addr = 32'h700;
        settle();
        chk_grant("rbusy_rst", 1'b0, 1'b0, 32'h0);
        chk("rbusy_rst_m_addr", m_addr, 32'h0);
        step(); reset_n = 1'b1; i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h99;
        settle();
        chk_grant("rbusy_stale", 1'b0, 1'b0, 32'h0);
        step(); m_rvalid = 1'b0; i_req = 1'b1;
        settle();
        chk_grant("rbusy_new", 1'b1, 1'b0, 32'h700);
        step(); i_req = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; push_i(32'hCAFEF00D);
        settle();
        step(); m_rvalid = 1'b0;
        settle();

        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
